// File: rtl/sd_types.sv
// Shared types and default parameters for the SD card DMA sequencer.
// Parameter defaults live here so every block and bench agrees on them.
package sd_types;

  localparam int SD_ADDR_W     = 15;
  localparam int SD_WORD_W     = 12;
  localparam int SD_SECT_WORDS = 256;
  localparam int SD_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    sdopNOP,
    sdopRD,
    sdopWR
  } sdOP_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_TAIL,
    ST_DONE
  } sd_state_t;

endpackage

// File: rtl/sd_dma_fifo.sv
// Small synchronous elastic buffer between the SD word stream and DMA.
// Flush empties it; push and pop together work even when full.
module sd_dma_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/sd_dma_seq.sv
// SD sector <-> PDP-8 DMA sequencer; define SD_DMA_CSUM_EN for the
// running checksum of DMA words on csum (otherwise csum is tied to 0).
module sd_dma_seq
  import sd_types::*;
#(
  parameter int ADDR_W     = SD_ADDR_W,
  parameter int WORD_W     = SD_WORD_W,
  parameter int SECT_WORDS = SD_SECT_WORDS,
  parameter int FIFO_DEPTH = SD_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  sdOP_t             op,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic              halfLen,
  input  logic [WORD_W-1:0] diskDATA,
  input  logic              diskVALID,
  output logic              diskREADY,
  output logic [WORD_W-1:0] wrDATA,
  output logic              wrVALID,
  input  logic              wrREADY,
  output logic              dmaREQ,
  input  logic              dmaGNT,
  output logic [ADDR_W-1:0] dmaADDR,
  output logic              dmaRD,
  output logic              dmaWR,
  output logic [WORD_W-1:0] dmaDOUT,
  input  logic [WORD_W-1:0] dmaDIN,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] csum
);

  localparam int CW = $clog2(SECT_WORDS) + 1;

  sd_state_t         state_q, state_d;
  sdOP_t             op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     mem_cnt_q, mem_cnt_d;
  logic [CW-1:0]     disk_cnt_q, disk_cnt_d;

  logic              f_push, f_pop, f_flush;
  logic              f_full, f_empty;
  logic [WORD_W-1:0] f_din, f_dout;
  logic              rd, xfer, disk_hs, launch;

  assign rd      = (op_q == sdopRD);
  assign dmaADDR = addr_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  sd_dma_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (f_flush),
    .push_i  (f_push),
    .din_i   (f_din),
    .pop_i   (f_pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    mem_cnt_d  = mem_cnt_q;
    disk_cnt_d = disk_cnt_q;
    f_push     = 1'b0;
    f_pop      = 1'b0;
    f_flush    = 1'b0;
    f_din      = diskDATA;
    diskREADY  = 1'b0;
    wrVALID    = 1'b0;
    wrDATA     = '0;
    dmaREQ     = 1'b0;
    dmaRD      = 1'b0;
    dmaWR      = 1'b0;
    dmaDOUT    = '0;
    xfer       = 1'b0;
    disk_hs    = 1'b0;
    launch     = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      f_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && op != sdopNOP) begin
            launch     = 1'b1;
            state_d    = ST_XFER;
            op_d       = op;
            addr_d     = memAddr;
            mem_cnt_d  = halfLen ? CW'(SECT_WORDS / 2)
                                 : CW'(SECT_WORDS);
            disk_cnt_d = CW'(SECT_WORDS);
            f_flush    = 1'b1;
          end
        end
        ST_XFER: begin
          if (rd) begin
            diskREADY = !f_full && disk_cnt_q != '0;
            disk_hs   = diskVALID && diskREADY;
            f_push    = disk_hs;
            dmaREQ    = !f_empty && mem_cnt_q != '0;
            xfer      = dmaREQ && dmaGNT;
            dmaWR     = xfer;
            f_pop     = xfer;
            dmaDOUT   = f_empty ? '0 : f_dout;
          end else begin
            dmaREQ  = !f_full && mem_cnt_q != '0;
            xfer    = dmaREQ && dmaGNT;
            dmaRD   = xfer;
            f_push  = xfer;
            f_din   = dmaDIN;
            wrVALID = !f_empty;
            wrDATA  = f_empty ? '0 : f_dout;
            disk_hs = wrVALID && wrREADY;
            f_pop   = disk_hs;
          end
          // Half sector: leftover buffered read words are discarded.
          if (disk_cnt_q == '0 && f_empty) begin
            state_d = ST_DONE;
          end else if (mem_cnt_q == '0 && (rd || f_empty)) begin
            state_d = ST_TAIL;
            f_flush = 1'b1;
          end
        end
        ST_TAIL: begin
          if (rd) begin
            diskREADY = (disk_cnt_q != '0);
            disk_hs   = diskVALID && diskREADY;
          end else begin
            wrVALID = (disk_cnt_q != '0);
            disk_hs = wrVALID && wrREADY;
          end
          if (disk_cnt_q == '0 && f_empty) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (xfer) begin
      addr_d    = addr_q + 1'b1;
      mem_cnt_d = mem_cnt_q - 1'b1;
    end
    if (disk_hs) disk_cnt_d = disk_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= sdopNOP;
      addr_q     <= '0;
      mem_cnt_q  <= '0;
      disk_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      mem_cnt_q  <= mem_cnt_d;
      disk_cnt_q <= disk_cnt_d;
    end
  end

`ifdef SD_DMA_CSUM_EN
  logic [WORD_W-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (launch) begin
      csum_q <= '0;
    end else if (xfer) begin
      csum_q <= csum_q + (rd ? f_dout : dmaDIN);
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_sd_dma_seq.sv
// Directed bench for sd_dma_seq: read/write, half sector, wrap,
// stalls with random grant, clear and reset aborts, checksum.
module tb_sd_dma_seq;
  import sd_types::*;

  localparam int AW = 15;
  localparam int WW = 12;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset, clear, start, halfLen;
  sdOP_t op;
  logic [AW-1:0] memAddr;
  logic [WW-1:0] diskDATA;
  logic diskVALID, diskREADY;
  logic [WW-1:0] wrDATA;
  logic wrVALID, wrREADY;
  logic dmaREQ, dmaGNT, dmaRD, dmaWR;
  logic [AW-1:0] dmaADDR;
  logic [WW-1:0] dmaDOUT, dmaDIN;
  logic busy, done;
  logic [WW-1:0] csum;

  logic gnt_fix, gnt_r, gnt_rand, din_fix;
  logic pat_ones, wr_exp_fix, chk_occ, abort;
  logic [AW-1:0] addr0;

  int n_pass = 0, n_chk = 0;
  int n_mw = 0, n_mr = 0, n_sd = 0, n_done = 0;
  int n_addr_err = 0, n_data_err = 0, n_wr_err = 0, n_full_err = 0;
  int occ = 0;
  int mw0, mr0, sd0, dn0, ae0, de0, we0, fe0;
  int got, feed_dn, k0;

  always #5 clk = ~clk;

  assign dmaGNT = gnt_rand ? gnt_r : gnt_fix;
  assign dmaDIN = din_fix ? 12'o5252 : WW'(dmaADDR) + 12'o123;

  sd_dma_seq dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .memAddr   (memAddr),
    .halfLen   (halfLen),
    .diskDATA  (diskDATA),
    .diskVALID (diskVALID),
    .diskREADY (diskREADY),
    .wrDATA    (wrDATA),
    .wrVALID   (wrVALID),
    .wrREADY   (wrREADY),
    .dmaREQ    (dmaREQ),
    .dmaGNT    (dmaGNT),
    .dmaADDR   (dmaADDR),
    .dmaRD     (dmaRD),
    .dmaWR     (dmaWR),
    .dmaDOUT   (dmaDOUT),
    .dmaDIN    (dmaDIN),
    .busy      (busy),
    .done      (done),
    .csum      (csum)
  );

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got_v, exp_v);
  endtask

  function automatic logic [WW-1:0] dword(input int k);
    return pat_ones ? WW'(1) : WW'(k);
  endfunction

  always @(posedge clk) begin
    #1;
    gnt_r = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin : mon
    int k;
    logic [WW-1:0] e;
    if (dmaWR) begin
      k = n_mw - mw0;
      if (dmaADDR !== AW'(int'(addr0) + k)) n_addr_err++;
      if (dmaDOUT !== dword(k)) n_data_err++;
      n_mw++;
    end
    if (dmaRD) begin
      k = n_mr - mr0;
      if (dmaADDR !== AW'(int'(addr0) + k)) n_addr_err++;
      n_mr++;
    end
    if (wrVALID && wrREADY) begin
      k = n_sd - sd0;
      if (wr_exp_fix) e = (k < 128) ? 12'o5252 : 12'o0000;
      else e = WW'(AW'(int'(addr0) + k)) + 12'o123;
      if (wrDATA !== e) n_wr_err++;
      n_sd++;
    end
    if (done) n_done++;
    if (start && !busy) begin
      occ = 0;
    end else begin
      if (chk_occ && dmaREQ && occ == FD) n_full_err++;
      occ = occ + int'(dmaRD) - int'(wrVALID && wrREADY);
    end
  end

  task automatic snap();
    mw0 = n_mw; mr0 = n_mr; sd0 = n_sd; dn0 = n_done;
    ae0 = n_addr_err; de0 = n_data_err;
    we0 = n_wr_err; fe0 = n_full_err;
  endtask

  task automatic do_start(input sdOP_t o, input logic [AW-1:0] a,
                          input logic h);
    @(posedge clk); #1;
    start = 1'b1; op = o; memAddr = a; halfLen = h;
    @(posedge clk); #1;
    start = 1'b0; op = sdopNOP;
  endtask

  task automatic disk_feed(input int n, output int cnt);
    int i, cyc;
    logic hs;
    i = 0;
    cyc = 0;
    diskVALID = 1'b1;
    diskDATA = dword(0);
    while (i < n && cyc < 4000 && !abort) begin
      @(negedge clk);
      hs = diskREADY;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        i++;
        diskDATA = dword(i);
      end
    end
    diskVALID = 1'b0;
    feed_dn = n_done;
    cnt = i;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy && c < budget);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_mw(input int n);
    int c;
    c = 0;
    while (n_mw - mw0 < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("wait_mw", 32'(n_mw - mw0 >= n), 1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; op = sdopNOP;
    memAddr = '0; halfLen = 1'b0; diskVALID = 1'b0; diskDATA = '0;
    wrREADY = 1'b0; gnt_fix = 1'b1; gnt_rand = 1'b0; din_fix = 1'b0;
    pat_ones = 1'b0; wr_exp_fix = 1'b0; chk_occ = 1'b0;
    abort = 1'b0; addr0 = '0;
    snap();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes",
        {dmaREQ, dmaRD, dmaWR, diskREADY, wrVALID, busy, done}, 0);
    chk("rst_addr", dmaADDR, 0);
    chk("rst_data", {wrDATA, dmaDOUT}, 0);
    chk("rst_csum", csum, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_start(sdopNOP, 15'o00100, 1'b0);
    @(negedge clk);
    chk("nop_busy", busy, 0);

    // full read from 00000, words 0000..0377
    snap(); addr0 = '0; pat_ones = 1'b0;
    do_start(sdopRD, 15'o00000, 1'b0);
    fork
      disk_feed(256, got);
      wait_idle(3000, "rd_full");
    join
    chk("rd_full_disk", got, 256);
    chk("rd_full_dmawr", n_mw - mw0, 256);
    chk("rd_full_addr_err", n_addr_err - ae0, 0);
    chk("rd_full_data_err", n_data_err - de0, 0);
    chk("rd_full_done", n_done - dn0, 1);
    chk("rd_full_endaddr", dmaADDR, 15'o00400);

    // half read: 128 DMA words, rest of sector discarded
    snap(); addr0 = 15'o01000;
    do_start(sdopRD, 15'o01000, 1'b1);
    fork
      disk_feed(256, got);
      wait_idle(3000, "rd_half");
    join
    chk("rd_half_disk", got, 256);
    chk("rd_half_dmawr", n_mw - mw0, 128);
    chk("rd_half_early_done", feed_dn - dn0, 0);
    chk("rd_half_done", n_done - dn0, 1);
    chk("rd_half_err", (n_addr_err - ae0) + (n_data_err - de0), 0);
    chk("rd_half_endaddr", dmaADDR, 15'o01200);

    // half write of 5252, zero-filled tail; second start ignored
    snap(); addr0 = 15'o02000; din_fix = 1'b1; wr_exp_fix = 1'b1;
    wrREADY = 1'b1;
    do_start(sdopWR, 15'o02000, 1'b1);
    do_start(sdopRD, 15'o00000, 1'b0);
    wait_idle(3000, "wr_half");
    chk("wr_half_dmard", n_mr - mr0, 128);
    chk("wr_half_sdwords", n_sd - sd0, 256);
    chk("wr_half_data_err", n_wr_err - we0, 0);
    chk("wr_half_addr_err", n_addr_err - ae0, 0);
    chk("wr_half_done", n_done - dn0, 1);
    chk("wr_half_dmawr", n_mw - mw0, 0);
    din_fix = 1'b0; wr_exp_fix = 1'b0;

    // full read across the top of memory
    snap(); addr0 = 15'o77770;
    do_start(sdopRD, 15'o77770, 1'b0);
    fork
      disk_feed(256, got);
      wait_idle(3000, "rd_wrap");
    join
    chk("rd_wrap_dmawr", n_mw - mw0, 256);
    chk("rd_wrap_addr_err", n_addr_err - ae0, 0);
    chk("rd_wrap_endaddr", dmaADDR, 15'o00370);
    chk("rd_wrap_done", n_done - dn0, 1);

    // full write, random grant, card stalled 50 cycles
    snap(); addr0 = 15'o00100; gnt_rand = 1'b1; chk_occ = 1'b1;
    wrREADY = 1'b0;
    do_start(sdopWR, 15'o00100, 1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("stall_req", dmaREQ, 0);
    chk("stall_wrvalid", wrVALID, 1);
    chk("stall_dmard", n_mr - mr0, FD);
    @(posedge clk); #1;
    wrREADY = 1'b1;
    wait_idle(5000, "wr_rand");
    chk("wr_rand_dmard", n_mr - mr0, 256);
    chk("wr_rand_sdwords", n_sd - sd0, 256);
    chk("wr_rand_data_err", n_wr_err - we0, 0);
    chk("wr_rand_full_err", n_full_err - fe0, 0);
    chk("wr_rand_done", n_done - dn0, 1);
    gnt_rand = 1'b0; chk_occ = 1'b0;

    // clear mid-read
    snap(); addr0 = '0;
    do_start(sdopRD, 15'o00000, 1'b0);
    fork
      disk_feed(256, got);
      begin
        wait_mw(100);
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        chk("clr_req", {dmaREQ, dmaWR, diskREADY}, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        chk("clr_busy", busy, 0);
      end
    join
    abort = 1'b0;
    k0 = n_mw;
    repeat (20) @(negedge clk);
    chk("clr_no_dma", n_mw - k0, 0);
    chk("clr_no_done", n_done - dn0, 0);

    // reset mid-read, card keeps offering data
    snap(); addr0 = 15'o00500;
    do_start(sdopRD, 15'o00500, 1'b0);
    fork
      disk_feed(256, got);
      begin
        wait_mw(20);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        abort = 1'b1;
      end
    join
    abort = 1'b0;
    diskVALID = 1'b1;
    k0 = n_mw;
    @(negedge clk);
    chk("rst_mid_state", {busy, diskREADY, dmaREQ}, 0);
    chk("rst_mid_addr", dmaADDR, 0);
    repeat (20) @(negedge clk);
    diskVALID = 1'b0;
    chk("rst_mid_no_dma", n_mw - k0, 0);
    chk("rst_mid_no_done", n_done - dn0, 0);

    // read of all-0001 words for the checksum
    snap(); addr0 = '0; pat_ones = 1'b1;
    do_start(sdopRD, 15'o00000, 1'b0);
    fork
      disk_feed(256, got);
      wait_idle(3000, "csum_rd");
    join
    chk("csum_data_err", n_data_err - de0, 0);
    chk("csum_done", n_done - dn0, 1);
`ifdef SD_DMA_CSUM_EN
    chk("csum_val", csum, 12'o0400);
`else
    chk("csum_off", csum, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_dma_seq.md
SD_DMA_SEQ -- requirements
Module: sd_dma_seq

Interface
REQ-001 Parameter ADDR_W, 15, DMA memory address width.
REQ-002 Parameter WORD_W, 12, data word width.
REQ-003 Parameter SECT_WORDS, 256, words per full sector; power of 2, >=4.
REQ-004 Parameter FIFO_DEPTH, 4, elastic buffer depth in words; power of 2, >=2.
REQ-005 Port clk  in  1  system clock, all logic on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port clear  in  1  synchronous IOCLR; aborts operation.
REQ-008 Ports start in 1 one-cycle launch; op in sdOP_t (sdopNOP/sdopRD/sdopWR); memAddr in ADDR_W start address; halfLen in 1 transfer SECT_WORDS/2 words.
REQ-009 Ports diskDATA in WORD_W, diskVALID in 1, diskREADY out 1: word stream from SD card (read path).
REQ-010 Ports wrDATA out WORD_W, wrVALID out 1, wrREADY in 1: word stream to SD card (write path).
REQ-011 Ports dmaREQ out 1, dmaGNT in 1, dmaADDR out ADDR_W, dmaRD out 1, dmaWR out 1, dmaDOUT out WORD_W, dmaDIN in WORD_W: PDP-8 DMA port.
REQ-012 Ports busy out 1, done out 1 (one-cycle pulse), csum out WORD_W (see Configuration).

Function
REQ-013 States IDLE, XFER, TAIL, DONE; IDLE->XFER on start with op!=sdopNOP; start with sdopNOP or while busy is ignored.
REQ-014 Start latches op, memAddr, halfLen; memCnt = halfLen ? SECT_WORDS/2 : SECT_WORDS; diskCnt = SECT_WORDS; FIFO flushed.
REQ-015 Read XFER: diskREADY = FIFO not full; each diskVALID&diskREADY cycle pushes diskDATA; dmaREQ = FIFO not empty and memCnt!=0.
REQ-016 Write XFER: dmaREQ = FIFO not full and memCnt!=0; granted word pushed from dmaDIN; wrVALID = FIFO not empty; pop on wrVALID&wrREADY.
REQ-017 DMA transfer occurs in each cycle dmaREQ&dmaGNT; dmaRD (write op) or dmaWR (read op) asserted combinationally that cycle; dmaADDR is current address.
REQ-018 Address increments by 1 per DMA transfer, modulo 2**ADDR_W (77777 wraps to 00000).
REQ-019 Read with halfLen: after memCnt reaches 0, TAIL consumes remaining disk words with diskREADY=1, discarding data, no DMA.
REQ-020 Write with halfLen: after memCnt reaches 0 and FIFO empty, TAIL drives wrDATA=0, wrVALID=1 until diskCnt reaches 0.
REQ-021 diskCnt decrements per disk-side word; XFER/TAIL->DONE when diskCnt=0 and FIFO empty; DONE->IDLE next cycle with done=1 for exactly that cycle.
REQ-022 busy = state!=IDLE; push and pop in same cycle keep occupancy unchanged, including when full.
REQ-023 clear in any state: IDLE next cycle, FIFO flushed, no done pulse; clear dominates start.

Reset
REQ-024 reset forces IDLE; dmaREQ, dmaRD, dmaWR, diskREADY, wrVALID, busy, done = 0; dmaADDR, wrDATA, dmaDOUT, csum = 0; FIFO empty.
REQ-025 reset mid-transfer abandons operation; no further DMA cycles after deassertion until new start.

Configuration
REQ-026 Macro SD_DMA_CSUM_EN defined: csum = modulo-2**WORD_W sum of all DMA-transferred words, cleared on start, valid when done pulses; undefined: csum tied to 0, no adder.

Structure
REQ-027 sdOP_t and state enum in package sd_types; parameter defaults in the shared parameters include.
REQ-028 One sub-module sd_dma_fifo (synchronous FIFO, WORD_W x FIFO_DEPTH, full/empty/flush).

Verification
REQ-029 Read, halfLen=0, memAddr=00000, disk words 0000..0377 -> 256 dmaWR cycles, addresses 00000..00377, data matches, one done pulse.
REQ-030 Read, halfLen=1 -> 128 dmaWR cycles, 128 disk words consumed without DMA, done after word 256.
REQ-031 Write, halfLen=1, dmaDIN=5252 -> 128 words 5252 then 128 words 0000 on wrDATA; 128 dmaRD cycles.
REQ-032 memAddr=77770, full read -> dmaADDR 77770..77777 then 00000..00367.
REQ-033 dmaGNT toggled randomly, wrREADY stalled 50 cycles at FIFO full -> no lost/duplicated words, dmaREQ low while full.
REQ-034 clear at word 100 of read -> IDLE next cycle, no done; with SD_DMA_CSUM_EN, uninterrupted read of words 0001 -> csum 0400.
